// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: valid/ready FIFO controller over a single-port 1024x10 ram
//   clk, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data      push side
//   out_valid/out_ready/out_data   pop side, out_data is a register
//   level, full, empty             occupancy (level counts words not yet issued)
//   ram_we/ram_address/ram_wdata/ram_rdata  ram port
//   almost_full, AFULL_LEVEL       present only when RAM_FIFO_AFULL_EN is defined
module ram_fifo_ctrl #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 10
`ifdef RAM_FIFO_AFULL_EN
    , parameter int AFULL_LEVEL = 1000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level,
    output logic              full,
    output logic              empty,
`ifdef RAM_FIFO_AFULL_EN
    output logic              almost_full,
`endif
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_pend;
    logic              issue;
    logic              push;
    logic [ADDR_W:0]   level_nxt;
    // A read-issue wins the ram port; pushes only use idle cycles.
    assign issue       = (level != '0) && !rd_pend && (!out_valid || out_ready);
    assign full        = level == DEPTH;
    assign empty       = level == '0 && !rd_pend && !out_valid;
    assign in_ready    = !full && !issue;
    assign push        = in_valid && in_ready;
    assign ram_we      = push;
    // Non-write cycles always present rd_ptr so the ram latches the next read slot.
    assign ram_address = push ? wr_ptr : rd_ptr;
    assign ram_wdata   = in_data;
    assign level_nxt   = push ? level + 1'b1 : issue ? level - 1'b1 : level;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rd_pend   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            level   <= level_nxt;
            rd_pend <= issue;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (issue)
                rd_ptr <= rd_ptr + 1'b1;
            // Issue needs a free or popping output register, so a capture never meets a held word.
            if (rd_pend) begin
                out_data  <= ram_rdata;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
`ifdef RAM_FIFO_AFULL_EN
    // Built from the next level so the flag tracks level without a cycle of lag.
    always_ff @(posedge clk) begin
        if (reset)
            almost_full <= 1'b0;
        else
            almost_full <= level_nxt >= (ADDR_W+1)'(AFULL_LEVEL);
    end
`endif
endmodule
